// File: rtl/multiword_subtractor.sv
// -----------------------------------------------------------------------------
// multiword_subtractor
//
// Sequential multi-word subtractor. It computes diff = a - b - borrow_in,
// modulo 2^(6*WORDS). Each clock processes one 6-bit slice, starting with the
// least significant slice, and the borrow ripples from one slice to the next.
// Results are registered. diff, borrow_out and zero keep the previous result
// for the whole run and change only when done pulses.
//
// Parameters
//   WORDS       number of 6-bit slices (operand width is 6*WORDS)
//
// Ports
//   clk         rising-edge clock for all state
//   reset       synchronous active-high reset
//   start       request a subtraction (sampled only while idle)
//   a, b        minuend and subtrahend, captured when start is accepted
//   borrow_in   initial borrow, captured when start is accepted
//   busy        high while slices are being processed (WORDS cycles)
//   done        one-cycle pulse marking a new valid result
//   diff        registered result
//   borrow_out  registered final borrow (1 iff a < b + borrow_in, unsigned)
//   zero        registered flag, high when diff is all zeros
// -----------------------------------------------------------------------------
module multiword_subtractor #(
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [6*WORDS-1:0]   a,
    input  logic [6*WORDS-1:0]   b,
    input  logic                 borrow_in,
    output logic                 busy,
    output logic                 done,
    output logic [6*WORDS-1:0]   diff,
    output logic                 borrow_out,
    output logic                 zero
);

    localparam int W    = 6 * WORDS;
    localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

    logic [0:0]      stateReg;
    logic [IDXW-1:0] indexReg;
    logic            borrowReg;
    logic [W-1:0]    workReg;
    logic [W-1:0]    aReg;
    logic [W-1:0]    bReg;
    logic [W-1:0]    diffReg;
    logic            borrowOutReg;
    logic            zeroReg;
    logic            doneReg;

    logic [5:0]      sliceA;
    logic [5:0]      sliceB;
    logic [5:0]      sliceDiff;
    logic [6:0]      borrowChain;
    logic [W-1:0]    workNext;

    genvar gi;

    // Select the operand slices addressed by the current index.
    always_comb begin
        sliceA = '0;
        sliceB = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (indexReg == IDXW'(i)) begin
                sliceA = aReg[i*6 +: 6];
                sliceB = bReg[i*6 +: 6];
            end
        end
    end

    // 6-bit ripple-borrow subtract. Bit 0 takes the borrow left by the
    // previous slice, or borrow_in for slice 0.
    assign borrowChain[0] = borrowReg;

    generate
        for (gi = 0; gi < 6; gi++) begin : g_bit
            assign sliceDiff[gi]     = sliceA[gi] ^ sliceB[gi] ^ borrowChain[gi];
            assign borrowChain[gi+1] = (~sliceA[gi] & sliceB[gi])
                                     | (~(sliceA[gi] ^ sliceB[gi]) & borrowChain[gi]);
        end
    endgenerate

    // Working register with the freshly computed slice merged in. The final
    // slice is taken from here, so diff is loaded in the same edge.
    generate
        for (gi = 0; gi < WORDS; gi++) begin : g_work
            assign workNext[gi*6 +: 6] = (indexReg == IDXW'(gi)) ? sliceDiff
                                                                : workReg[gi*6 +: 6];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            stateReg     <= IDLE;
            indexReg     <= '0;
            borrowReg    <= 1'b0;
            workReg      <= '0;
            aReg         <= '0;
            bReg         <= '0;
            diffReg      <= '0;
            borrowOutReg <= 1'b0;
            zeroReg      <= 1'b1;
            doneReg      <= 1'b0;
        end else begin
            doneReg <= 1'b0;
            case (stateReg)
                IDLE: begin
                    if (start) begin
                        aReg      <= a;
                        bReg      <= b;
                        borrowReg <= borrow_in;
                        indexReg  <= '0;
                        workReg   <= '0;
                        stateReg  <= RUN;
                    end
                end
                RUN: begin
                    workReg   <= workNext;
                    borrowReg <= borrowChain[6];
                    if (indexReg == LAST_IDX) begin
                        diffReg      <= workNext;
                        borrowOutReg <= borrowChain[6];
                        zeroReg      <= (workNext == '0);
                        doneReg      <= 1'b1;
                        indexReg     <= '0;
                        stateReg     <= IDLE;
                    end else begin
                        indexReg <= indexReg + IDXW'(1);
                    end
                end
                default: stateReg <= IDLE;
            endcase
        end
    end

    assign busy       = (stateReg == RUN);
    assign done       = doneReg;
    assign diff       = diffReg;
    assign borrow_out = borrowOutReg;
    assign zero       = zeroReg;

endmodule

// File: tb/tb_multiword_subtractor.sv
// -----------------------------------------------------------------------------
// tb_multiword_subtractor
//
// Directed testbench for multiword_subtractor with WORDS=4. The driver issues
// operations and pushes the hand-computed expected results, tagged with the
// cycle in which done must appear, into a scoreboard queue. An independent
// monitor samples the outputs 1 time unit after every rising edge. It checks
// each done pulse against the head of the queue, checks that the outputs hold
// while busy, and checks the values after reset.
// -----------------------------------------------------------------------------
module tb_multiword_subtractor;

    localparam int WORDS = 4;
    localparam int W     = 6 * WORDS;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         borrow_in = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;
    logic         zero;

    multiword_subtractor #(.WORDS(WORDS)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .a          (a),
        .b          (b),
        .borrow_in  (borrow_in),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out),
        .zero       (zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
        logic         z;
        int           doneCycle;
    } exp_t;

    exp_t sbq[$];

    int cycleCnt   = 0;
    int compared   = 0;
    int mismatched = 0;

    always @(posedge clk) cycleCnt++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cycleCnt);
        end
    endtask

    // ---------------------------------------------------------------- monitor
    initial begin : monitor
        logic [W-1:0] lastD;
        logic         lastBo;
        logic         lastZ;
        int           busyRun;
        exp_t         e;
        lastD   = '0;
        lastBo  = 1'b0;
        lastZ   = 1'b1;
        busyRun = 0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                check("reset_busy", 32'(busy), 32'd0);
                check("reset_done", 32'(done), 32'd0);
                check("reset_diff", 32'(diff), 32'd0);
                check("reset_borrow_out", 32'(borrow_out), 32'd0);
                check("reset_zero", 32'(zero), 32'd1);
                lastD   = '0;
                lastBo  = 1'b0;
                lastZ   = 1'b1;
                busyRun = 0;
            end else begin
                if (sbq.size() > 0 && sbq[0].doneCycle < cycleCnt) begin
                    check("missing_done", 32'(cycleCnt), 32'(sbq[0].doneCycle));
                    void'(sbq.pop_front());
                end
                if (done) begin
                    if (sbq.size() == 0) begin
                        check("unexpected_done", 32'(done), 32'd0);
                    end else begin
                        e = sbq.pop_front();
                        $display("txn: diff=0x%06h borrow_out=%0d zero=%0d at cycle %0d",
                                 diff, borrow_out, zero, cycleCnt);
                        check("diff", 32'(diff), 32'(e.d));
                        check("borrow_out", 32'(borrow_out), 32'(e.bo));
                        check("zero", 32'(zero), 32'(e.z));
                        check("done_latency", 32'(cycleCnt), 32'(e.doneCycle));
                        check("busy_cycles", 32'(busyRun), 32'(WORDS));
                        lastD  = e.d;
                        lastBo = e.bo;
                        lastZ  = e.z;
                    end
                    check("busy_in_done_cycle", 32'(busy), 32'd0);
                    busyRun = 0;
                end else if (busy) begin
                    busyRun++;
                    check("hold_diff", 32'(diff), 32'(lastD));
                    check("hold_borrow_out", 32'(borrow_out), 32'(lastBo));
                    check("hold_zero", 32'(zero), 32'(lastZ));
                end else begin
                    busyRun = 0;
                end
            end
        end
    end

    // ----------------------------------------------------------------- driver
    // Called at a falling edge. Start is sampled at the next rising edge, so
    // done must appear WORDS edges after that one.
    task automatic issueOp(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin,
                           input logic [W-1:0] ed, input logic eb, input logic ez,
                           input bit track);
        exp_t e;
        a         = ia;
        b         = ib;
        borrow_in = ibin;
        start     = 1'b1;
        if (track) begin
            e.d         = ed;
            e.bo        = eb;
            e.z         = ez;
            e.doneCycle = cycleCnt + 1 + WORDS;
            sbq.push_back(e);
        end
        @(negedge clk);
        start     = 1'b0;
        a         = W'($urandom);
        b         = W'($urandom);
        borrow_in = 1'($urandom_range(0, 1));
    endtask

    logic [W-1:0] vA [9];
    logic [W-1:0] vB [9];
    logic         vBin [9];
    logic [W-1:0] vD [9];
    logic         vBo [9];
    logic         vZ [9];

    initial begin : driver
        vA   = '{24'h000006, 24'h00003C, 24'h000000, 24'h000040, 24'h123456,
                 24'h123456, 24'hFFFFFF, 24'h800000, 24'h000000};
        vB   = '{24'h000005, 24'h000003, 24'h000001, 24'h000001, 24'h123456,
                 24'h123456, 24'h000000, 24'h7FFFFF, 24'hFFFFFF};
        vBin = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        vD   = '{24'h000001, 24'h000038, 24'hFFFFFF, 24'h00003F, 24'h000000,
                 24'hFFFFFF, 24'hFFFFFE, 24'h000001, 24'h000000};
        vBo  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vZ   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

        @(negedge clk);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Directed vectors, each followed by an idle gap.
        for (int i = 0; i < 9; i++) begin
            issueOp(vA[i], vB[i], vBin[i], vD[i], vBo[i], vZ[i], 1'b1);
            repeat (WORDS + 1) @(negedge clk);
        end

        // A second start while busy must be ignored.
        issueOp(24'h100000, 24'h000001, 1'b0, 24'h0FFFFF, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        a         = 24'h000000;
        b         = 24'h000002;
        borrow_in = 1'b0;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (WORDS + 2) @(negedge clk);

        // Back-to-back: each new start is driven in the previous done cycle.
        issueOp(24'h654321, 24'h111111, 1'b0, 24'h543210, 1'b0, 1'b0, 1'b1);
        repeat (WORDS) @(negedge clk);
        issueOp(24'h000010, 24'h000020, 1'b0, 24'hFFFFF0, 1'b1, 1'b0, 1'b1);
        repeat (WORDS) @(negedge clk);
        issueOp(24'h0F0F0F, 24'h0F0F0F, 1'b1, 24'hFFFFFF, 1'b1, 1'b0, 1'b1);
        repeat (WORDS + 2) @(negedge clk);

        // Reset in the second RUN cycle aborts the operation with no done.
        issueOp(24'h000000, 24'h000001, 1'b0, 24'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (WORDS + 3) @(negedge clk);

        // Recovery after the abort.
        issueOp(24'h000006, 24'h000005, 1'b0, 24'h000001, 1'b0, 1'b0, 1'b1);
        repeat (WORDS + 1) @(negedge clk);

        for (int t = 0; t < 100 && sbq.size() > 0; t++) @(negedge clk);
        if (sbq.size() > 0) check("drain_timeout", 32'(sbq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/multiword_subtractor.md
MULTIWORD_SUBTRACTOR -- requirements
Module: multiword_subtractor

Interface
REQ-001 The block SHALL have parameter WORDS, default 4, giving the number of 6-bit slices; the operand width is 6*WORDS bits (24 at default).
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 Port clk  input  1  rising-edge clock for all state.
REQ-004 Port reset  input  1  synchronous active-high reset.
REQ-005 Port start  input  1  request to begin a subtraction; sampled only in IDLE.
REQ-006 Port a  input  6*WORDS  minuend, captured when start is accepted.
REQ-007 Port b  input  6*WORDS  subtrahend, captured when start is accepted.
REQ-008 Port borrow_in  input  1  initial borrow, captured when start is accepted.
REQ-009 Port busy  output  1  high while slices are being processed.
REQ-010 Port done  output  1  one-cycle pulse marking a new valid result.
REQ-011 Port diff  output  6*WORDS  registered result a - b - borrow_in, modulo 2^(6*WORDS).
REQ-012 Port borrow_out  output  1  registered final borrow of the last slice.
REQ-013 Port zero  output  1  registered flag, high when diff is all zeros.

Function
REQ-014 The block SHALL compute the result one 6-bit slice per clock, LSB slice first, using a 6-bit ripple-borrow subtract (per bit: d = a^b^bin; bout = (~a&b) | (~(a^b)&bin)).
REQ-015 The FSM SHALL have two states: IDLE and RUN.
REQ-016 In IDLE, start=1 at a rising edge SHALL capture a, b and borrow_in, clear the slice index to 0, and move to RUN.
REQ-017 In IDLE with start=0, the block SHALL hold all outputs.
REQ-018 In RUN, each rising edge SHALL compute slice[index] from the captured operands and the borrow register, store the slice into an internal working register, update the borrow register, and increment the index.
REQ-019 On the edge that processes slice WORDS-1, the block SHALL load diff from the working register (including that final slice) and load borrow_out and zero, then return to IDLE.
REQ-020 done SHALL be 1 exactly in the cycle following that edge, and 0 at all other times.
REQ-021 Latency SHALL be fixed. With start sampled at edge k, the result and done SHALL be visible after edge k+WORDS.
REQ-022 busy SHALL be 1 exactly while the state is RUN (WORDS cycles per operation).
REQ-023 diff, borrow_out and zero SHALL hold the previous result throughout RUN; partial slices SHALL never appear on outputs.
REQ-024 start SHALL be ignored while in RUN, and changes on a, b or borrow_in SHALL not affect an operation in progress.
REQ-025 start=1 in the done cycle (state IDLE) SHALL be accepted, giving back-to-back operations with no idle gap.
REQ-026 The borrow SHALL chain between slices; slice 0 uses the captured borrow_in.
REQ-027 borrow_out SHALL be 1 if and only if a < b + borrow_in, treating the operands as unsigned.

Reset
REQ-028 reset=1 at a rising edge SHALL force state IDLE, index 0, borrow register 0, working register 0, busy 0, done 0, diff 0, borrow_out 0, and zero 1.
REQ-029 Reset SHALL take priority over start and over any operation in progress; an aborted operation SHALL produce no done pulse.

Verification
REQ-030 Directed scenarios with WORDS=4:
- Basic subtract: a=0x000006, b=0x000005, bin=0 -> diff=0x000001, borrow_out=0, zero=0, done exactly 4 cycles after start edge, busy high 4 cycles.
- Subtract with borrow_in: a=0x00003C, b=0x000003, bin=1 -> diff=0x000038, borrow_out=0.
- Full underflow: a=0x000000, b=0x000001, bin=0 -> diff=0xFFFFFF, borrow_out=1. The borrow propagates through all four slices.
- Inter-slice borrow: a=0x000040, b=0x000001 -> diff=0x00003F, borrow_out=0.
- Equal operands: a=b=0x123456, bin=0 -> diff=0, zero=1, borrow_out=0. Repeating with bin=1 -> diff=0xFFFFFF, borrow_out=1, zero=0.
- Control corner cases:
  - A second start during busy is ignored, and the outputs keep the prior result until done.
  - A start in the done cycle produces the next result 4 cycles later.
  - Reset asserted at cycle 2 of RUN gives busy=0, diff=0, zero=1, and no done pulse.
